// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: shared FSM states, opcode width and opcode constants for the ALU scheduler
package alu_sched_pkg;
  localparam int OP_W = 4;
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_RESP} state_e;
  localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
  localparam logic [OP_W-1:0] OP_MUL  = 4'd2;
  localparam logic [OP_W-1:0] OP_DIV  = 4'd3;
  localparam logic [OP_W-1:0] OP_AND  = 4'd4;
  localparam logic [OP_W-1:0] OP_OR   = 4'd5;
  localparam logic [OP_W-1:0] OP_XOR  = 4'd6;
  localparam logic [OP_W-1:0] OP_NAND = 4'd7;
  localparam logic [OP_W-1:0] OP_NOR  = 4'd8;
  localparam logic [OP_W-1:0] OP_XNOR = 4'd9;
  localparam logic [OP_W-1:0] OP_SHL  = 4'd10;
  localparam logic [OP_W-1:0] OP_SHR  = 4'd11;
  localparam logic [OP_W-1:0] OP_GT   = 4'd12;
  localparam logic [OP_W-1:0] OP_LT   = 4'd13;
  localparam logic [OP_W-1:0] OP_EQ   = 4'd14;
  localparam logic [OP_W-1:0] OP_INC  = 4'd15;
endpackage

// File: rtl/alu_sched_rr_arb2.sv
// rr_arb2: two-way round-robin picker; on a tie the port not granted last wins
module rr_arb2 (
  input  logic       valid0_i,
  input  logic       valid1_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);
  // one-hot grant: tie resolved against the last winner, otherwise the lone requester
  always_comb gnt_o = (valid0_i && valid1_i) ? (last_i ? 2'b01 : 2'b10) : {valid1_i, valid0_i};
endmodule

// File: rtl/alu_sched.sv
// alu_sched: round-robin scheduler feeding a shared combinational ALU; optional grant stats under ALU_SCHED_STATS_EN
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int DATA_W        = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W:0]   alu_res,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W:0]   rsp_data,
`ifdef ALU_SCHED_STATS_EN
  output logic [7:0]        grant_cnt0,
  output logic [7:0]        grant_cnt1,
`endif
  output logic              busy
);
  localparam int CNT_W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("alu_sched: SETTLE_CYCLES must be at least 1");
  end
  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              last_q;
  logic [DATA_W-1:0] alu_a_q, alu_b_q;
  logic [OP_W-1:0]   alu_op_q;
  logic              rsp_id_q;
  logic [DATA_W:0]   rsp_data_q;
  logic [1:0]        gnt;
  logic              acc0, acc1;
  rr_arb2 u_arb (
    .valid0_i (req0_valid),
    .valid1_i (req1_valid),
    .last_i   (last_q),
    .gnt_o    (gnt)
  );
  assign req0_ready = (state_q == S_IDLE) && gnt[0];
  assign req1_ready = (state_q == S_IDLE) && gnt[1];
  assign acc0       = req0_valid && req0_ready;
  assign acc1       = req1_valid && req1_ready;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_valid  = state_q == S_RESP;
  assign busy       = state_q != S_IDLE;
  // accept -> hold operands for the settle time -> capture -> wait for response handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      last_q     <= 1'b1;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      rsp_id_q   <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (acc0 || acc1) begin
          alu_a_q  <= acc1 ? req1_a : req0_a;
          alu_b_q  <= acc1 ? req1_b : req0_b;
          alu_op_q <= acc1 ? req1_op : req0_op;
          rsp_id_q <= acc1;
          last_q   <= acc1;
          cnt_q    <= CNT_W'(SETTLE_CYCLES);
          state_q  <= S_SETTLE;
        end
        S_SETTLE: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            rsp_data_q <= alu_res;
            state_q    <= S_RESP;
          end
        end
        S_RESP: if (rsp_ready) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end
`ifdef ALU_SCHED_STATS_EN
  logic [7:0] grant_cnt0_q, grant_cnt1_q;
  assign grant_cnt0 = grant_cnt0_q;
  assign grant_cnt1 = grant_cnt1_q;
  // per-port accept counters, saturating at 255
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_cnt0_q <= '0;
      grant_cnt1_q <= '0;
    end else begin
      grant_cnt0_q <= (acc0 && grant_cnt0_q != 8'hFF) ? grant_cnt0_q + 8'd1 : grant_cnt0_q;
      grant_cnt1_q <= (acc1 && grant_cnt1_q != 8'hFF) ? grant_cnt1_q + 8'd1 : grant_cnt1_q;
    end
  end
`endif
endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: directed self-checking bench for alu_sched with a behavioural ALU on the alu_* bus
module tb_alu_sched;
  logic       clk, rst_n;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0] req0_a, req0_b, req0_op, req1_a, req1_b, req1_op;
  logic [3:0] alu_a, alu_b, alu_op;
  logic [4:0] alu_res, rsp_data;
  logic       rsp_valid, rsp_ready, rsp_id, busy;
`ifdef ALU_SCHED_STATS_EN
  logic [7:0] grant_cnt0, grant_cnt1;
`endif
  int n_chk = 0;
  int n_err = 0;

  alu_sched #(.SETTLE_CYCLES(1), .DATA_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_res    (alu_res),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
`ifdef ALU_SCHED_STATS_EN
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1),
`endif
    .busy       (busy)
  );

  // behavioural stand-in for the gate-level ALU: {carry, result}
  function automatic logic [4:0] alu_f(logic [3:0] a, logic [3:0] b, logic [3:0] op);
    case (op)
      4'd0:    alu_f = {1'b0, a} + {1'b0, b};
      4'd1:    alu_f = {1'b0, a} - {1'b0, b};
      4'd4:    alu_f = {1'b0, a & b};
      4'd5:    alu_f = {1'b0, a | b};
      4'd6:    alu_f = {1'b0, a ^ b};
      4'd10:   alu_f = {1'b0, a << b};
      default: alu_f = 5'd0;
    endcase
  endfunction
  assign alu_res = alu_f(alu_a, alu_b, alu_op);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(string tag);
    int n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 1);
  endtask

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    tick(); tick();
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_alu_a", 32'(alu_a), 0);
    check("rst_alu_b", 32'(alu_b), 0);
    check("rst_alu_op", 32'(alu_op), 0);
    check("rst_rsp_data", 32'(rsp_data), 0);
    check("rst_rsp_id", 32'(rsp_id), 0);
    rst_n = 1'b1;
    // 1: single ADD 4+3
    req0_valid = 1'b1; req0_a = 4; req0_b = 3; req0_op = 0;
    #1;
    check("t1_ready0", 32'(req0_ready), 1);
    check("t1_ready1", 32'(req1_ready), 0);
    tick();
    req0_valid = 1'b0;
    check("t1_alu_a", 32'(alu_a), 4);
    check("t1_alu_b", 32'(alu_b), 3);
    check("t1_alu_op", 32'(alu_op), 0);
    check("t1_busy", 32'(busy), 1);
    check("t1_no_rsp_yet", 32'(rsp_valid), 0);
    tick();
    check("t1_rsp_valid", 32'(rsp_valid), 1);
    check("t1_rsp_data", 32'(rsp_data), 7);
    check("t1_rsp_id", 32'(rsp_id), 0);
    tick();
    check("t1_idle_valid", 32'(rsp_valid), 0);
    check("t1_idle_busy", 32'(busy), 0);
    // 2: simultaneous requests after reset, req0 first
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    req0_valid = 1'b1; req0_a = 10; req0_b = 10; req0_op = 4;
    req1_valid = 1'b1; req1_a = 15; req1_b = 6;  req1_op = 6;
    wait_rsp("t2a");
    check("t2a_id", 32'(rsp_id), 0);
    check("t2a_data", 32'(rsp_data[3:0]), 10);
    tick();
    wait_rsp("t2b");
    check("t2b_id", 32'(rsp_id), 1);
    check("t2b_data", 32'(rsp_data[3:0]), 9);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    // 3: both held valid, grants alternate starting with req0
    req0_valid = 1'b1; req0_a = 3; req0_b = 2; req0_op = 10;
    req1_valid = 1'b1; req1_a = 7; req1_b = 8; req1_op = 5;
    for (int i = 0; i < 4; i++) begin
      wait_rsp("t3");
      check("t3_id", 32'(rsp_id), 32'(i % 2));
      check("t3_data", 32'(rsp_data[3:0]), (i % 2) ? 15 : 12);
      if (i == 3) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
      end
      tick();
    end
    // 4: backpressure in RESP, ADD 9+8 with carry
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 9; req0_b = 8; req0_op = 0;
    wait_rsp("t4");
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 2; req1_b = 2; req1_op = 0;
    #1;
    for (int k = 0; k < 5; k++) begin
      check("t4_hold_valid", 32'(rsp_valid), 1);
      check("t4_hold_data", 32'(rsp_data), 17);
      check("t4_hold_ready0", 32'(req0_ready), 0);
      check("t4_hold_ready1", 32'(req1_ready), 0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check("t4_release_ready1", 32'(req1_ready), 0);
    tick();
    check("t4_idle_busy", 32'(busy), 0);
    check("t4_idle_ready1", 32'(req1_ready), 1);
    tick();
    check("t4_accept_busy", 32'(busy), 1);
    check("t4_accept_alu_a", 32'(alu_a), 2);
    check("t4_accept_id", 32'(rsp_id), 1);
    req1_valid = 1'b0;
    wait_rsp("t4b");
    check("t4b_data", 32'(rsp_data), 4);
    tick();
    // 5: reset during SETTLE after a req1 grant; first tie afterwards goes to req0
    req1_valid = 1'b1; req1_a = 9; req1_b = 1; req1_op = 0;
    tick();
    check("t5_busy", 32'(busy), 1);
    check("t5_id", 32'(rsp_id), 1);
    check("t5_alu_a", 32'(alu_a), 9);
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_a = 5; req0_b = 5; req0_op = 0;
    tick();
    check("t5_rst_valid", 32'(rsp_valid), 0);
    check("t5_rst_busy", 32'(busy), 0);
    check("t5_rst_alu_a", 32'(alu_a), 0);
    check("t5_rst_alu_b", 32'(alu_b), 0);
    check("t5_rst_alu_op", 32'(alu_op), 0);
    check("t5_rst_id", 32'(rsp_id), 0);
    check("t5_rst_data", 32'(rsp_data), 0);
    rst_n = 1'b1;
    #1;
    check("t5_tie_ready0", 32'(req0_ready), 1);
    check("t5_tie_ready1", 32'(req1_ready), 0);
    tick();
    check("t5_tie_alu_a", 32'(alu_a), 5);
    check("t5_tie_id", 32'(rsp_id), 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_rsp("t5b");
    check("t5b_data", 32'(rsp_data), 10);
    tick();
`ifdef ALU_SCHED_STATS_EN
    // 6: saturating grant counters
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check("t6_cnt0_rst", 32'(grant_cnt0), 0);
    check("t6_cnt1_rst", 32'(grant_cnt1), 0);
    begin
      int acc = 0;
      int cyc = 0;
      req1_valid = 1'b1; req1_a = 1; req1_b = 1; req1_op = 0;
      #1;
      while (acc < 260 && cyc < 2000) begin
        if (req1_ready) acc++;
        tick();
        cyc++;
      end
      req1_valid = 1'b0;
      check("t6_accepts", 32'(acc), 260);
    end
    check("t6_cnt1", 32'(grant_cnt1), 255);
    check("t6_cnt0", 32'(grant_cnt0), 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
